// File: rtl/text_sequencer_pkg.sv
// Shared definitions for the text overlay sequencer.
// State encodings and cell geometry.
package text_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_ENTER = 2'd0,
    ST_HOLD  = 2'd1,
    ST_EXIT  = 2'd2,
    ST_GAP   = 2'd3
  } seq_state_e;

  localparam int CELL_SHIFT  = 3;
  localparam int SCREEN_COLS = 80;
  localparam int TEXT_ROWS   = 10;

endpackage

// File: rtl/text_sequencer_cell_map.sv
// Registered pixel -> cell coordinate mapping.
// One clock of latency; runs every cycle.
module text_sequencer_cell_map
  import text_sequencer_pkg::*;
#(
  parameter int ROW = 38
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       display_on,
  input  logic [6:0] org_x,
  output logic [6:0] cell_x,
  output logic [5:0] cell_y,
  output logic       pix_valid
);

  localparam logic [5:0] ROW_C = 6'(ROW);

  logic [6:0] cell_x_q, cell_x_d;
  logic [5:0] cell_y_q, cell_y_d;
  logic       pix_valid_q;
  logic       unused_bits;

  assign unused_bits = ^{x[2:0], y[9], y[2:0]};

  // Modulo-128 wrap pushes pixels left of the origin past MSG_COLS
  always_comb begin
    cell_x_d = x[9:CELL_SHIFT] - org_x;
    cell_y_d = y[8:CELL_SHIFT] - ROW_C;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cell_x_q    <= '0;
      cell_y_q    <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      cell_x_q    <= cell_x_d;
      cell_y_q    <= cell_y_d;
      pix_valid_q <= display_on;
    end
  end

  assign cell_x    = cell_x_q;
  assign cell_y    = cell_y_q;
  assign pix_valid = pix_valid_q;

endmodule

// File: rtl/text_sequencer.sv
// Frame-rate text overlay sequencer: slide in, hold,
// blink, slide out, gap, next message.
module text_sequencer
  import text_sequencer_pkg::*;
#(
  parameter int NUM_MSG      = 4,
  parameter int START_COL    = 80,
  parameter int TARGET_COL   = 11,
  parameter int ROW          = 38,
  parameter int MSG_COLS     = 61,
  parameter int STEP_FRAMES  = 2,
  parameter int HOLD_FRAMES  = 180,
  parameter int BLINK_FRAMES = 30,
  parameter int GAP_FRAMES   = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               frame_tick,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               display_on,
  input  logic [NUM_MSG-1:0] text_hit,
  output logic [6:0]         cell_x,
  output logic [5:0]         cell_y,
  output logic               overlay_active,
  output logic [1:0]         msg_sel,
  output logic               msg_done
);

  localparam logic [6:0] START_C  = 7'(START_COL);
  localparam logic [6:0] TARGET_C = 7'(TARGET_COL);
  localparam logic [6:0] COLS_C   = 7'(MSG_COLS);
  localparam logic [5:0] ROWS_C   = 6'(TEXT_ROWS);
  localparam logic [7:0] STEP_LST = 8'(STEP_FRAMES - 1);
  localparam logic [7:0] HOLD_LST = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0] GAP_LST  = 8'(GAP_FRAMES - 1);
  localparam logic [7:0] BLINK_ST = 8'(HOLD_FRAMES - BLINK_FRAMES);
  localparam logic [1:0] MSG_LST  = 2'(NUM_MSG - 1);

  seq_state_e state_q, state_d;
  logic [6:0] org_q, org_d;
  logic [7:0] step_q, step_d;
  logic [7:0] frame_q, frame_d;
  logic [1:0] msg_q, msg_d;
  logic       done_q, done_d;
  logic [6:0] org_dn, org_up;
  logic       show;
  logic       hit_sel;
  logic       pix_valid;

  text_sequencer_cell_map #(
    .ROW(ROW)
  ) u_map (
    .clk        (clk),
    .rst        (rst),
    .x          (x),
    .y          (y),
    .display_on (display_on),
    .org_x      (org_q),
    .cell_x     (cell_x),
    .cell_y     (cell_y),
    .pix_valid  (pix_valid)
  );

  assign org_dn = org_q - 7'd1;
  assign org_up = org_q + 7'd1;

  // Counters only move on an enabled frame tick, so org never tears
  always_comb begin
    state_d = state_q;
    org_d   = org_q;
    step_d  = step_q;
    frame_d = frame_q;
    msg_d   = msg_q;
    done_d  = 1'b0;
    if (frame_tick && enable) begin
      unique case (state_q)
        ST_ENTER: begin
          if (step_q == STEP_LST) begin
            step_d = '0;
            org_d  = org_dn;
            if (org_dn == TARGET_C) begin
              state_d = ST_HOLD;
              frame_d = '0;
            end
          end else begin
            step_d = step_q + 8'd1;
          end
        end
        ST_HOLD: begin
          if (frame_q == HOLD_LST) begin
            state_d = ST_EXIT;
            step_d  = '0;
          end else begin
            frame_d = frame_q + 8'd1;
          end
        end
        ST_EXIT: begin
          if (step_q == STEP_LST) begin
            step_d = '0;
            org_d  = org_up;
            if (org_up == START_C) begin
              state_d = ST_GAP;
              frame_d = '0;
              done_d  = 1'b1;
            end
          end else begin
            step_d = step_q + 8'd1;
          end
        end
        ST_GAP: begin
          if (frame_q == GAP_LST) begin
            state_d = ST_ENTER;
            step_d  = '0;
            msg_d   = (msg_q == MSG_LST) ? 2'd0 : msg_q + 2'd1;
          end else begin
            frame_d = frame_q + 8'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ENTER;
      org_q   <= START_C;
      step_q  <= '0;
      frame_q <= '0;
      msg_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      org_q   <= org_d;
      step_q  <= step_d;
      frame_q <= frame_d;
      msg_q   <= msg_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    show = 1'b0;
    unique case (state_q)
      ST_ENTER: show = 1'b1;
      ST_EXIT:  show = 1'b1;
      ST_HOLD:  show = !((frame_q >= BLINK_ST) && frame_q[3]);
      ST_GAP:   show = 1'b0;
    endcase
  end

  always_comb begin
    hit_sel = 1'b0;
    for (int i = 0; i < NUM_MSG; i++) begin
      if (msg_q == 2'(i)) hit_sel = text_hit[i];
    end
  end

  assign overlay_active = pix_valid & show & (cell_x < COLS_C)
                        & (cell_y < ROWS_C) & hit_sel;
  assign msg_sel  = msg_q;
  assign msg_done = done_q;

endmodule
